// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB master.
// Holds the transfer FSM state encoding and default bus widths.
package apb_pkg;

    // Default APB address and data widths.
    localparam int APB_ADDWIDTH  = 8;
    localparam int APB_DATAWIDTH = 32;

    // Transfer FSM: IDLE waits for a command, SETUP drives the first
    // APB phase, ACCESS holds until the slave completes (or timeout).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB bus signals.
// Ports (master view): cmd_valid/write/addr/wdata/strb in,
//   cmd_ready out; rsp_valid/rdata/timeout out; PSEL, PENABLE,
//   PWRITE, PADDR, PWDATA, PSTRB out; PREADY, PRDATA in.
//   The slave modport is the mirror image, used by the bus model.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDWIDTH  = APB_ADDWIDTH,
    parameter int DATAWIDTH = APB_DATAWIDTH
) ();

    // Command side
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDWIDTH-1:0]    cmd_addr;
    logic [DATAWIDTH-1:0]   cmd_wdata;
    logic [DATAWIDTH/8-1:0] cmd_strb;

    // Response side
    logic                   rsp_valid;
    logic [DATAWIDTH-1:0]   rsp_rdata;
    logic                   rsp_timeout;

    // APB side
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDWIDTH-1:0]    PADDR;
    logic [DATAWIDTH-1:0]   PWDATA;
    logic [DATAWIDTH/8-1:0] PSTRB;
    logic                   PREADY;
    logic [DATAWIDTH-1:0]   PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts consecutive stalled ACCESS cycles.
// Ports: clk, rst (async, active-high); clear restarts the count;
//   inc marks a stalled cycle; expired is high in the stalled cycle
//   that reaches LIMIT, so the FSM can abort at the following edge.
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // cnt holds the stalled cycles already seen, so the current
    // stalled cycle is the LIMIT-th one when cnt == LIMIT-1.
    assign expired = inc && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master: turns single commands into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse on completion.
// Ports: PCLK, PRESET (async, active-high), bus (apb_master_if.master)
//   carrying the cmd_*, rsp_* and APB signals.
// Optional: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
//   TIMEOUT_CYCLES stalled cycles with rsp_timeout=1.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDWIDTH       = APB_ADDWIDTH,
    parameter int DATAWIDTH      = APB_DATAWIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    localparam int SW = DATAWIDTH / 8;

    apb_state_t state;
    apb_state_t state_nxt;

    logic cmd_ready;
    logic psel;
    logic penable;
    logic accept;
    logic done_ok;
    logic tmo;

    // Latched request; held through IDLE until the next command.
    logic                 pwrite_q;
    logic [ADDWIDTH-1:0]  paddr_q;
    logic [DATAWIDTH-1:0] pwdata_q;
    logic [SW-1:0]        pstrb_q;

    // Response registers.
    logic                 rsp_valid_q;
    logic [DATAWIDTH-1:0] rsp_rdata_q;

    assign accept  = bus.cmd_valid && cmd_ready;
    assign done_ok = (state == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_tmo_q;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (state == SETUP),
        .inc     ((state == ACCESS) && !bus.PREADY),
        .expired (tmo)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_tmo_q <= 1'b0;
        end else begin
            rsp_tmo_q <= tmo;
        end
    end

    assign bus.rsp_timeout = rsp_tmo_q;
`else
    // No timeout: ACCESS waits for PREADY forever.
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign tmo                   = 1'b0;
    assign bus.rsp_timeout       = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (done_ok || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; PSEL/PENABLE come straight from state so reset
    // clears them without waiting for a clock edge.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            SETUP: begin
                psel = 1'b1;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Request latch; reads drive zero data and zero strobes.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
        end
    end

    // Response: one-cycle pulse, rdata held until the next completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done_ok || tmo;
            if (done_ok) begin
                rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            end else if (tmo) begin
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master with a memory slave.
// Covers directed scenarios, random traffic, timeout and async reset.
module tb_apb_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          cyc;
    } req_t;

    logic PCLK;
    logic PRESET;

    apb_master_if #(.ADDWIDTH(AW), .DATAWIDTH(DW)) bus ();

    apb_master #(
        .ADDWIDTH       (AW),
        .DATAWIDTH      (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    rsp_t exp_q[$];
    req_t req_q[$];
    int   wait_q[$];

    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];
    bit          slv_init = 0;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] last_rdata = 0;

    int          s_w;
    int          s_k;
    logic [44:0] s_snap;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(posedge PCLK) begin : mon
        rsp_t e;
        #1;
        if (!PRESET) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_timeout", bus.rsp_timeout, e.tmo);
                    chk("rsp_cycle", cyc, e.cyc);
                    last_rdata = e.rdata;
                end
            end else begin
                chk("rdata_hold", bus.rsp_rdata, last_rdata);
                if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_rsp: no rsp_valid at cycle %0d, expected at %0d",
                             cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
            chk("cmd_ready_idle", bus.cmd_ready, !bus.PSEL);
        end
    end

    // APB memory slave and request checker
    always @(posedge PCLK) begin : slave
        req_t r;
        #1;
        if (!slv_init) begin
            for (int i = 0; i < 256; i++) slv_mem[i] = ref_mem[i];
            slv_init = 1;
        end
        if (PRESET || !bus.PSEL) begin
            bus.PREADY = 1'b0;
            bus.PRDATA = $urandom;
            s_k = 0;
        end else if (!bus.PENABLE) begin
            bus.PREADY = 1'b0;
            s_k = 0;
            s_snap = {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB};
            if (req_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_setup: PSEL=1 at cycle %0d, expected 0", cyc);
            end else begin
                r = req_q.pop_front();
                chk("setup_paddr", bus.PADDR, r.addr);
                chk("setup_pwrite", bus.PWRITE, r.wr);
                chk("setup_pwdata", bus.PWDATA, r.wdata);
                chk("setup_pstrb", bus.PSTRB, r.strb);
                chk("setup_cycle", cyc, r.cyc);
            end
            s_w = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end else begin
            chk("access_stable",
                {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB}, s_snap);
            bus.PREADY = (s_k == s_w);
            bus.PRDATA = $urandom;
            if (bus.PREADY) begin
                if (bus.PWRITE) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.PSTRB[b])
                            slv_mem[bus.PADDR][8*b +: 8] = bus.PWDATA[8*b +: 8];
                end else begin
                    bus.PRDATA = slv_mem[bus.PADDR];
                end
            end
            s_k++;
        end
    end

    // Present one command and hold it until accepted; the reference
    // model decides the response at acceptance time.
    task automatic issue(input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input int w, input bit want_rsp);
        int   n = 0;
        bit   ok = 0;
        int   acc;
        req_t r;
        rsp_t e;
        while (!ok) begin
            @(negedge PCLK);
            bus.cmd_valid = 1'b1;
            bus.cmd_write = wr;
            bus.cmd_addr  = a;
            bus.cmd_wdata = d;
            bus.cmd_strb  = s;
            if (bus.cmd_ready) begin
                ok = 1;
            end else if (++n > 200) begin
                tests++;
                fails++;
                $display("FAIL cmd_accept: cmd_ready=0 for 200 cycles, expected 1");
                return;
            end
        end
        acc = cyc + 1;
        r.addr  = a;
        r.wr    = wr;
        r.wdata = wr ? d : 32'h0;
        r.strb  = wr ? s : 4'h0;
        r.cyc   = acc;
        req_q.push_back(r);
        wait_q.push_back(w);
        if (want_rsp) begin
            if (w < 0) begin
                e.rdata = 32'h0;
                e.tmo   = 1'b1;
                e.cyc   = acc + 1 + TO;
            end else begin
                e.rdata = wr ? 32'h0 : ref_mem[a];
                e.tmo   = 1'b0;
                e.cyc   = acc + 2 + w;
            end
            exp_q.push_back(e);
        end
        if (wr && w >= 0) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic idle(input int n);
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || bus.PSEL) && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Assert reset in the middle of a stalled ACCESS.
    task automatic reset_mid();
        @(negedge PCLK);
        chk("in_access_before_reset", {bus.PSEL, bus.PENABLE}, 2'b11);
        #1;
        PRESET = 1'b1;
        last_rdata = 32'h0;
        #1;
        chk("reset_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
        chk("reset_apb_req",
            {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB}, 45'h0);
        chk("reset_rsp",
            {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}, 34'h0);
        exp_q.delete();
        req_q.delete();
        wait_q.delete();
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("ready_after_reset", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        PCLK          = 1'b0;
        PRESET        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;

        #1;
        PRESET = 1'b1;
        #1;
        chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
        chk("reset_apb_req",
            {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB}, 45'h0);
        chk("reset_rsp",
            {bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}, 34'h0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        // Basic write, read-back, stalled write, partial-strobe readback
        issue(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1);
        idle(0);
        wait_done();
        issue(0, 8'h10, 32'h12345678, 4'hA, 0, 1);
        idle(0);
        wait_done();
        issue(1, 8'h20, 32'hCAFEF00D, 4'h5, 3, 1);
        idle(0);
        wait_done();
        issue(0, 8'h20, 32'h0, 4'h0, 1, 1);
        idle(2);
        wait_done();

        // cmd_valid held across three commands
        issue(1, 8'h30, 32'hA5A55A5A, 4'hF, 0, 1);
        issue(0, 8'h30, 32'hFFFFFFFF, 4'hF, 0, 1);
        issue(0, 8'h10, 32'h0, 4'h0, 2, 1);
        idle(0);
        wait_done();

        // Random traffic over a small address window
        for (int t = 0; t < 80; t++) begin
            issue(1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)),
                  $urandom,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
        end
        idle(0);
        wait_done();

`ifdef APB_MASTER_TIMEOUT_EN
        issue(0, 8'h05, 32'h0, 4'h0, -1, 1);
        idle(0);
        wait_done();
        issue(1, 8'h06, 32'h11223344, 4'hF, -1, 1);
        idle(0);
        wait_done();
        issue(0, 8'h06, 32'h0, 4'h0, 0, 1);
        idle(0);
        wait_done();
`else
        issue(0, 8'h05, 32'h0, 4'h0, -1, 0);
        idle(0);
        repeat (100) @(negedge PCLK);
        chk("no_timeout_still_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        reset_mid();
`endif

        // Reset during the second ACCESS cycle of a stalled read
        issue(0, 8'h07, 32'h0, 4'h0, -1, 0);
        idle(1);
        reset_mid();
        repeat (3) @(negedge PCLK);

        // Recovery after reset
        issue(0, 8'h10, 32'h0, 4'h0, 2, 1);
        idle(0);
        wait_done();
        issue(1, 8'h10, 32'h0BADF00D, 4'h3, 0, 1);
        issue(0, 8'h10, 32'h0, 4'h0, 0, 1);
        idle(2);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDWIDTH, default 8, APB address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have ports, in this order:
- PCLK  in  1  -- single clock, all logic rising-edge.
- PRESET  in  1  -- reset, asynchronous, active-high.
- cmd_valid  in  1  -- command request.
- cmd_ready  out  1  -- command accepted when high with cmd_valid.
- cmd_write  in  1  -- 1 write, 0 read.
- cmd_addr  in  ADDWIDTH  -- target address.
- cmd_wdata  in  DATAWIDTH  -- write data.
- cmd_strb  in  DATAWIDTH/8  -- write byte strobes.
- rsp_valid  out  1  -- one-cycle completion pulse.
- rsp_rdata  out  DATAWIDTH  -- read data; 0 for writes.
- rsp_timeout  out  1  -- completion was a timeout abort.
- PSEL, PENABLE, PWRITE  out  1 each  -- APB control.
- PADDR  out  ADDWIDTH; PWDATA  out  DATAWIDTH; PSTRB  out  DATAWIDTH/8  -- APB request.
- PREADY  in  1; PRDATA  in  DATAWIDTH  -- APB completion.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-006 cmd_ready SHALL be high exactly when state is IDLE.
REQ-007 On an edge with cmd_valid && cmd_ready: SHALL latch cmd_write/addr/wdata/strb and go to SETUP; cmd_* SHALL be ignored in other states.
REQ-008 SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA/PSTRB from latched command; next state ACCESS unconditionally.
REQ-009 ACCESS: PSEL=1, PENABLE=1; all APB request outputs SHALL remain stable while PREADY=0.
REQ-010 ACCESS with PREADY=1: SHALL return to IDLE and assert rsp_valid for exactly the following cycle, with rsp_rdata = PRDATA sampled at that edge for reads and 0 for writes; rsp_timeout=0.
REQ-011 For reads, PSTRB SHALL be 0 and PWDATA SHALL be 0.
REQ-012 IDLE: PSEL=0, PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB SHALL hold their last values.
REQ-013 A new command SHALL be acceptable in the same cycle rsp_valid is high; minimum transfer period is 3 cycles; no PSEL gap-free back-to-back transfers.
REQ-014 rsp_rdata SHALL hold its value until the next completion.

Reset
REQ-015 PRESET high SHALL immediately force state IDLE, and set PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata and rsp_timeout to 0, without waiting for PCLK.
REQ-016 A transfer interrupted by reset SHALL be discarded without a response; after release, cmd_ready SHALL be 1.

Configuration
REQ-017 With APB_MASTER_TIMEOUT_EN defined: SHALL count consecutive ACCESS cycles with PREADY=0. On reaching TIMEOUT_CYCLES, SHALL go to IDLE and pulse rsp_valid with rsp_timeout=1 and rsp_rdata=0. The counter SHALL clear on each SETUP.
REQ-018 Without APB_MASTER_TIMEOUT_EN: the counter SHALL be absent, ACCESS SHALL wait indefinitely, and rsp_timeout SHALL be tied 0.

Structure
REQ-019 Package apb_pkg SHALL hold the FSM state typedef (IDLE/SETUP/ACCESS) and default ADDWIDTH/DATAWIDTH constants.
REQ-020 The timeout counter SHALL be sub-module apb_timeout_cnt, instantiated only under APB_MASTER_TIMEOUT_EN; the rest stays flat.

Verification
REQ-021 Write 0x10/0xDEADBEEF/strb 0xF, accepted at edge N, PREADY=PSEL&PENABLE -> SETUP cycle N+1, ACCESS cycle N+2, rsp_valid=1 cycle N+3, rsp_rdata=0.
REQ-022 Read 0x10, slave returns 0xDEADBEEF -> PWRITE=0, PSTRB=0, rsp_rdata=0xDEADBEEF, one rsp_valid pulse.
REQ-023 PREADY low for 3 ACCESS cycles -> 4 ACCESS cycles with PADDR/PWDATA/PSTRB stable, then rsp_valid=1 for one cycle.
REQ-024 Macro on, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_timeout=1, rsp_rdata=0. Macro off -> still in ACCESS after 100 cycles.
REQ-025 PRESET pulsed mid-ACCESS -> PSEL/PENABLE 0 before the next edge, no rsp_valid, cmd_ready=1 after release.
REQ-026 cmd_valid held for two commands -> second accepted in the rsp_valid cycle; PSEL rises every 3 cycles.
